// File: rtl/ram_dp_if.sv
// Write/read port bundle for the simple-dual-port RAM.
// Master drives requests; slave returns read data and status.
interface ram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                    w_en;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH/8-1:0] w_be;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    r_en;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    r_valid;
    logic                    busy;

    modport master (
        output w_en, w_addr, w_be, data_in, r_en, r_addr,
        input  data_out, r_valid, busy
    );

    modport slave (
        input  w_en, w_addr, w_be, data_in, r_en, r_addr,
        output data_out, r_valid, busy
    );
endinterface

// File: rtl/ram_dp.sv
// Simple-dual-port RAM with byte enables and selectable read-during-write.
// Define RAM_CLEAR_EN to build the post-reset zero-fill sequencer.
module ram_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RDW_MODE   = 0
) (
    input  logic     clk,
    input  logic     rst,
    ram_dp_if.slave  bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;

    logic                  w_busy;
    logic                  w_w_inrange;
    logic                  w_r_inrange;
    logic                  w_w_ok;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [NB-1:0]         w_wbe;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_w_inrange = {1'b0, bus.w_addr} < LP_DEPTH;
    assign w_r_inrange = {1'b0, bus.r_addr} < LP_DEPTH;
    assign w_w_ok      = bus.w_en && !w_busy && w_w_inrange;

`ifdef RAM_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == LP_LAST)
                r_state <= ST_READY;
        end
    end

    assign w_busy = (r_state == ST_CLEAR);
`else
    assign w_busy = 1'b0;
`endif

    // The clear sequencer, when present, owns the write port while busy.
    always_comb begin
        w_we    = w_w_ok;
        w_waddr = bus.w_addr;
        w_wbe   = bus.w_be;
        w_wdata = bus.data_in;
`ifdef RAM_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wbe   = '1;
            w_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_wbe[i])
                    r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Array read yields the pre-write word; mode 1 forwards enabled bytes.
    always_comb begin
        w_rd_word = '0;
        if (w_r_inrange) begin
            w_rd_word = r_mem[bus.r_addr];
            if (RDW_MODE == 1 && w_w_ok && bus.w_addr == bus.r_addr) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.w_be[i])
                        w_rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (bus.r_en && !w_busy) begin
            r_dout  <= w_rd_word;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.data_out = r_dout;
    assign bus.r_valid  = r_valid;
    assign bus.busy     = w_busy;
endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: RDW old/new instances plus a DEPTH=12 one.
// Shared stimulus drives all three; vectors carry per-mode expectations.
module tb_ram_dp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_en = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [3:0]  w_be = '0;
    logic [31:0] data_in = '0;
    logic        r_en = 1'b0;
    logic [3:0]  r_addr = '0;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef RAM_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    always #5 clk = ~clk;

    ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b0 ();
    ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b1 ();
    ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b2 ();

    assign b0.w_en = w_en;    assign b1.w_en = w_en;    assign b2.w_en = w_en;
    assign b0.w_addr = w_addr; assign b1.w_addr = w_addr; assign b2.w_addr = w_addr;
    assign b0.w_be = w_be;    assign b1.w_be = w_be;    assign b2.w_be = w_be;
    assign b0.data_in = data_in; assign b1.data_in = data_in; assign b2.data_in = data_in;
    assign b0.r_en = r_en;    assign b1.r_en = r_en;    assign b2.r_en = r_en;
    assign b0.r_addr = r_addr; assign b1.r_addr = r_addr; assign b2.r_addr = r_addr;

    ram_dp #(.DATA_WIDTH(32), .DEPTH(16), .RDW_MODE(0)) u_old (
        .clk(clk), .rst(rst), .bus(b0)
    );
    ram_dp #(.DATA_WIDTH(32), .DEPTH(16), .RDW_MODE(1)) u_new (
        .clk(clk), .rst(rst), .bus(b1)
    );
    ram_dp #(.DATA_WIDTH(32), .DEPTH(12), .RDW_MODE(0)) u_d12 (
        .clk(clk), .rst(rst), .bus(b2)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        chk;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic we, logic [3:0] wa, logic [3:0] be,
                         logic [31:0] wd, logic re, logic [3:0] ra);
        @(negedge clk);
        w_en = we; w_addr = wa; w_be = be; data_in = wd;
        r_en = re; r_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(string name);
        int edges;
        edges = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            edges = e;
            if (!b0.busy) break;
        end
        check(name, 32'(edges), 32'd16);
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1, 3, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 4'h0, 0, 1, 3, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1, 7, 4'hF, 32'h12345678, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 7, 4'h5, 32'hAABBCCDD, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 4'h0, 0, 1, 7, 1, 32'h12BB56DD, 32'h12BB56DD};
        tbl[5]  = '{1, 5, 4'hF, 32'h11111111, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 5, 4'hF, 32'h22222222, 1, 5, 1, 32'h11111111, 32'h22222222};
        tbl[7]  = '{0, 0, 4'h0, 0, 1, 5, 1, 32'h22222222, 32'h22222222};
        tbl[8]  = '{1, 9, 4'hF, 32'h0BADF00D, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 2, 4'hF, 32'hCAFEF00D, 1, 9, 1, 32'h0BADF00D, 32'h0BADF00D};
        tbl[10] = '{0, 0, 4'h0, 0, 1, 2, 1, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[11] = '{1, 5, 4'h3, 32'h33333333, 1, 5, 1, 32'h22222222, 32'h22223333};
        tbl[12] = '{0, 0, 4'h0, 0, 0, 0, 1, 32'h22222222, 32'h22223333};
        tbl[13] = '{0, 0, 4'h0, 0, 1, 5, 1, 32'h22223333, 32'h22223333};
        tbl[14] = '{1, 5, 4'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 15, 4'hF, 32'hA5A5A5A5, 1, 5, 1, 32'h22223333, 32'h22223333};
        tbl[16] = '{0, 0, 4'h0, 0, 1, 15, 1, 32'hA5A5A5A5, 32'hA5A5A5A5};

        #2;
        check("rst data_out", b0.data_out, 32'h0);
        check("rst r_valid", 32'(b0.r_valid), 32'h0);
        check("rst busy", 32'(b0.busy), 32'(EXP_BUSY));

`ifdef RAM_CLEAR_EN
        // Write attempted during clear must be dropped.
        @(negedge clk);
        rst = 1'b0;
        w_en = 1'b1; w_addr = 4; w_be = 4'hF; data_in = 32'hFFFFFFFF;
        count_busy("clear edges");
        @(negedge clk);
        w_en = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid-clear busy", 32'(b0.busy), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        count_busy("restart clear edges");

        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 1, 4'(a));
            check($sformatf("cleared[%0d]", a), b0.data_out, 32'h0);
        end
`else
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("busy idle", 32'(b0.busy), 32'h0);
`endif

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].wd,
                  tbl[i].re, tbl[i].ra);
            check($sformatf("v%0d r_valid old", i), 32'(b0.r_valid), 32'(tbl[i].re));
            check($sformatf("v%0d r_valid new", i), 32'(b1.r_valid), 32'(tbl[i].re));
            if (tbl[i].chk) begin
                check($sformatf("v%0d data old", i), b0.data_out, tbl[i].e0);
                check($sformatf("v%0d data new", i), b1.data_out, tbl[i].e1);
            end
        end

        drive(1, 1, 4'hF, 32'h01010101, 0, 0);
        drive(1, 13, 4'hF, 32'hFFFFFFFF, 0, 0);
        drive(0, 0, 4'h0, 0, 1, 13);
        check("d12 oor data", b2.data_out, 32'h0);
        check("d12 oor r_valid", 32'(b2.r_valid), 32'h1);
        drive(0, 0, 4'h0, 0, 1, 1);
        check("d12 addr1", b2.data_out, 32'h01010101);

        // Reset while a read result is standing.
        @(negedge clk);
        r_en = 1'b1; r_addr = 3;
        @(posedge clk);
        #2;
        check("pre-rst r_valid", 32'(b0.r_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("async rst r_valid", 32'(b0.r_valid), 32'h0);
        check("async rst data", b0.data_out, 32'h0);
        check("async rst busy", 32'(b0.busy), 32'(EXP_BUSY));
        r_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_dp.md
# ram_dp

Parametrised simple-dual-port synchronous RAM: one write port and one read port on a single clock. It adds per-byte write enables, a selectable read-during-write mode, a registered read-valid flag and an optional post-reset clear sequencer to the single-port `ram` it succeeds. It is the storage primitive for register files, scratchpads and FIFO backing stores that need a concurrent read and write in one cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width in bits; must be a multiple of 8.
- `DEPTH`, 16, number of words; any value ≥ 2, need not be a power of two.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width.
- `RDW_MODE`, 0, same-address read-during-write behaviour: 0 = old data, 1 = new data.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `w_en`  in  1  write request.
- `w_addr`  in  ADDR_WIDTH  write address.
- `w_be`  in  DATA_WIDTH/8  byte enables; bit i selects `data_in[8i+7:8i]`.
- `data_in`  in  DATA_WIDTH  write data.
- `r_en`  in  1  read request.
- `r_addr`  in  ADDR_WIDTH  read address.
- `data_out`  out  DATA_WIDTH  registered read data.
- `r_valid`  out  1  `data_out` updated by the read accepted on the previous edge.
- `busy`  out  1  clear sequence in progress; all requests are ignored.

## Operation
- Write: on an edge where `w_en`=1, `busy`=0 and `w_addr`<DEPTH, each byte i with `w_be[i]`=1 is stored; bytes with `w_be[i]`=0 keep their value. `w_be`=0 is a no-op.
- Read: on an edge where `r_en`=1 and `busy`=0, `data_out` loads `mem[r_addr]` and `r_valid` goes to 1. Otherwise `r_valid` goes to 0 and `data_out` holds its value.
- Out of range (address ≥ DEPTH, non-power-of-two DEPTH only): the write is dropped; the read returns 0 with `r_valid`=1.
- Read-during-write, same address, same edge:
  - `RDW_MODE`=0: `data_out` returns the pre-write word.
  - `RDW_MODE`=1: per byte, an enabled byte returns `data_in` and a disabled byte returns the stored byte.
  - Different addresses never interact.
- Clear FSM (only when `RAM_CLEAR_EN` is defined): two states, CLEAR and READY.
  - `rst` forces state CLEAR and counter `clr_addr`=0.
  - In CLEAR, each edge writes all-zero to `mem[clr_addr]` and increments `clr_addr`.
  - When `clr_addr`=DEPTH-1 is written, the FSM goes to READY.
  - READY is held until the next `rst`.
- Memory contents are not affected by `rst` except through the clear FSM.

## Timing
- Reset values: `data_out`=0, `r_valid`=0, `busy`=1 with `RAM_CLEAR_EN` and 0 without it. Asserting `rst` sets these immediately, independent of `clk`.
- Read latency: 1 cycle. `data_out` and `r_valid` are valid after the edge that samples `r_en`. Back-to-back reads give one word per cycle.
- Write-to-read: a read sampled on the edge after a write returns the new data in both `RDW_MODE` settings.
- Clear timing: `busy` stays high for the DEPTH edges after `rst` deasserts. The first access that is accepted is the one sampled on edge DEPTH+1.
- `rst` asserted mid-clear: the sequence restarts from address 0.
- `rst` asserted mid-operation: any in-flight read is lost and `r_valid`=0.

## Configuration
- `RAM_CLEAR_EN` defined:
  - The clear FSM and counter are built.
  - `busy` behaves as specified above.
  - Every word reads 0 after reset until it is written.
- `RAM_CLEAR_EN` undefined:
  - No FSM or counter is built.
  - `busy` is tied to 0 and accesses are accepted on the first edge after `rst` deasserts.
  - Contents after power-up are undefined (X in simulation).

## Test plan
Configuration for all scenarios: DATA_WIDTH=32, DEPTH=16.
- Full-word write/read: write 3←0xDEADBEEF with `w_be`=0xF, then read 3 → `data_out`=0xDEADBEEF and `r_valid`=1 one cycle after `r_en`.
- Byte enables: write 7←0x12345678 with `w_be`=0xF, then 7←0xAABBCCDD with `w_be`=0x5 → read 7 returns 0x12BB56DD.
- Read-during-write, same edge, addr 5 holding 0x11111111, write 0x22222222 with `w_be`=0xF:
  - `RDW_MODE`=0 → 0x11111111.
  - `RDW_MODE`=1 → 0x22222222.
- Simultaneous write to 2 and read of 9 (holding 0x0BADF00D) → `data_out`=0x0BADF00D; a read of 2 on the next edge returns the new data.
- With `RAM_CLEAR_EN`: release `rst` → `busy`=1 for exactly 16 edges and a write issued during `busy` is ignored. After that, reads of 0..15 all return 0. Reasserting `rst` at edge 8 of the clear restarts the 16-edge count.
- With DEPTH=12: write 13←0xFFFFFFFF, then read 13 → 0 with `r_valid`=1; addr 1 (13 mod 12) is unchanged.
